// File: rtl/wb_stage.sv
//==============================================================================
// Module   : wb_stage
// Purpose  : DLX write-back stage. Holds the MEM/WB register, waits for
//            variable-latency load data and drives the register-file write port.
//            Optional retire counter is enabled by defining WB_RETIRE_CNT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result_in,
    input  logic [4:0]  write_reg_in,
    input  logic        reg_write_in,
    input  logic        memtoreg_in,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        err_spurious
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_count
`endif
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_MEM = 2'd1;
    localparam logic [1:0] S_COMMIT   = 2'd2;
    localparam logic [4:0] c_ZERO_REG = 5'd0;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_accept;
    logic        w_load_accept;
    logic        w_spurious;
    logic        r_pend_we;
    logic [4:0]  r_pend_reg;
    logic        r_out_we;
    logic [4:0]  r_out_reg;
    logic [31:0] r_out_data;
    logic        r_err;
    logic        w_commit_we;
    logic [4:0]  w_commit_reg;
    logic [31:0] w_commit_data;

    assign w_accept      = in_valid && in_ready;
    assign w_load_accept = w_accept && memtoreg_in;
    // Only an outstanding load or a load accepted in the same cycle may consume rvalid.
    assign w_spurious    = mem_rvalid && (r_state != S_WAIT_MEM) && !w_load_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    w_next_state = S_COMMIT;
                end
            end
            default: begin
                if (w_accept) begin
                    w_next_state = (!memtoreg_in || mem_rvalid) ? S_COMMIT : S_WAIT_MEM;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        in_ready  = (r_state != S_WAIT_MEM);
        reg_write = (r_state == S_COMMIT) && r_out_we;
    end

    // Commit source: pending load fields while waiting, otherwise the incoming instruction.
    always_comb begin
        if (r_state == S_WAIT_MEM) begin
            w_commit_we   = r_pend_we;
            w_commit_reg  = r_pend_reg;
            w_commit_data = mem_rdata;
        end else begin
            w_commit_we   = reg_write_in;
            w_commit_reg  = write_reg_in;
            w_commit_data = memtoreg_in ? mem_rdata : alu_result_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_we  <= 1'b0;
            r_pend_reg <= 5'd0;
            r_out_we   <= 1'b0;
            r_out_reg  <= 5'd0;
            r_out_data <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_we  <= reg_write_in;
                r_pend_reg <= write_reg_in;
            end
            if (w_next_state == S_COMMIT) begin
                r_out_we   <= w_commit_we && (w_commit_reg != c_ZERO_REG);
                r_out_reg  <= w_commit_reg;
                r_out_data <= w_commit_data;
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    assign write_reg    = r_out_reg;
    assign write_data   = r_out_data;
    assign err_spurious = r_err;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire_count <= 32'd0;
        end else if (r_state == S_COMMIT) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
//==============================================================================
// Module   : tb_wb_stage
// Purpose  : Self-checking bench for wb_stage against a transaction-level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_in;
    logic [4:0]  write_reg_in;
    logic        reg_write_in;
    logic        memtoreg_in;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        err_spurious;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: an outstanding-load flag plus the result of the latest commit.
    bit          m_load_waiting;
    bit          m_pend_we;
    logic [4:0]  m_pend_reg;
    bit          m_committing;
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_err;
    logic [31:0] m_cnt;

    wb_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result_in (alu_result_in),
        .write_reg_in  (write_reg_in),
        .reg_write_in  (reg_write_in),
        .memtoreg_in   (memtoreg_in),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .err_spurious  (err_spurious)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count  (retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_load_waiting = 0;
        m_pend_we      = 0;
        m_pend_reg     = '0;
        m_committing   = 0;
        m_we           = 0;
        m_reg          = '0;
        m_data         = '0;
        m_err          = 0;
        m_cnt          = '0;
    endtask

    task automatic check_outputs();
        chk("in_ready",     {31'd0, in_ready},     {31'd0, !m_load_waiting});
        chk("reg_write",    {31'd0, reg_write},    {31'd0, m_committing && m_we});
        chk("write_reg",    {27'd0, write_reg},    {27'd0, m_reg});
        chk("write_data",   write_data,            m_data);
        chk("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});
`ifdef WB_RETIRE_CNT_EN
        chk("retire_count", retire_count, m_cnt);
`endif
    endtask

    // One cycle: check current outputs, drive inputs, predict the state after the edge.
    task automatic step(input bit v, input logic [31:0] alu, input logic [4:0] wr,
                        input bit rw, input bit mtr, input logic [31:0] rd, input bit rv);
        bit          accept;
        bit          commit;
        bit          c_we;
        logic [4:0]  c_reg;
        logic [31:0] c_data;
        @(negedge clk);
        check_outputs();
        in_valid      = v;
        alu_result_in = alu;
        write_reg_in  = wr;
        reg_write_in  = rw;
        memtoreg_in   = mtr;
        mem_rdata     = rd;
        mem_rvalid    = rv;

        accept = v && !m_load_waiting;
        commit = 0;
        c_we   = 0;
        c_reg  = '0;
        c_data = '0;
        if (rv && !m_load_waiting && !(accept && mtr)) m_err = 1;
        if (m_load_waiting) begin
            if (rv) begin
                commit = 1; c_we = m_pend_we; c_reg = m_pend_reg; c_data = rd;
                m_load_waiting = 0;
            end
        end else if (accept) begin
            if (!mtr) begin
                commit = 1; c_we = rw; c_reg = wr; c_data = alu;
            end else if (rv) begin
                commit = 1; c_we = rw; c_reg = wr; c_data = rd;
            end else begin
                m_load_waiting = 1; m_pend_we = rw; m_pend_reg = wr;
            end
        end
        if (m_committing) m_cnt = m_cnt + 32'd1;
        m_committing = commit;
        if (commit) begin
            m_we   = c_we && (c_reg != 5'd0);
            m_reg  = c_reg;
            m_data = c_data;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, 32'd0, 5'd0, 0, 0, 32'd0, 0);
    endtask

    task automatic quiet_inputs();
        in_valid = 0; alu_result_in = '0; write_reg_in = '0;
        reg_write_in = 0; memtoreg_in = 0; mem_rdata = '0; mem_rvalid = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    initial begin
        quiet_inputs();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();
        #1;
        chk("rst_in_ready",   {31'd0, in_ready},  32'd1);
        chk("rst_reg_write",  {31'd0, reg_write}, 32'd0);
        chk("rst_write_reg",  {27'd0, write_reg}, 32'd0);
        chk("rst_write_data", write_data,         32'd0);

        // ALU stream, back-to-back
        step(1, 32'h11, 5'd1, 1, 0, 32'd0, 0);
        step(1, 32'h22, 5'd2, 1, 0, 32'd0, 0);
        step(1, 32'h33, 5'd3, 1, 0, 32'd0, 0);
        idle(); idle();

        // Load to r7 with data three cycles later
        step(1, 32'h100, 5'd7, 1, 1, 32'd0, 0);
        idle(); idle();
        step(0, 32'd0, 5'd0, 0, 0, 32'hDEADBEEF, 1);
        idle();

        // Load with data at accept, then an ALU op in the commit cycle
        step(1, 32'h200, 5'd4, 1, 1, 32'hA5A5A5A5, 1);
        step(1, 32'h55, 5'd6, 1, 0, 32'd0, 0);
        idle();

        // Write to r0 is suppressed but still commits
        step(1, 32'h99, 5'd0, 1, 0, 32'd0, 0);
        idle();

        // Spurious rvalid in idle is sticky
        step(0, 32'd0, 5'd0, 0, 0, 32'h12345678, 1);
        idle(); idle();

        // Async reset during a commit drops reg_write without a clock edge
        step(1, 32'h77, 5'd9, 1, 0, 32'd0, 0);
        @(negedge clk);
        chk("pre_rst_reg_write", {31'd0, reg_write}, 32'd1);
        quiet_inputs();
        reset = 1;
        #1;
        chk("async_rst_reg_write", {31'd0, reg_write},    32'd0);
        chk("async_rst_err",       {31'd0, err_spurious}, 32'd0);
        release_reset();

        // Reset mid-load with r5 latched
        step(1, 32'd0, 5'd5, 1, 1, 32'd0, 0);
        idle();
        @(negedge clk);
        chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
        quiet_inputs();
        reset = 1;
        #1;
        chk("midload_rst_reg_write", {31'd0, reg_write}, 32'd0);
        release_reset();
        #1;
        chk("midload_in_ready",   {31'd0, in_ready},     32'd1);
        chk("midload_write_reg",  {27'd0, write_reg},    32'd0);
        chk("midload_write_data", write_data,            32'd0);
        chk("midload_err",        {31'd0, err_spurious}, 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bit v, mtr, rv;
            v   = ($urandom % 4) != 0;
            mtr = ($urandom % 2) == 1;
            if (m_load_waiting)  rv = ($urandom % 3) == 0;
            else if (v && mtr)   rv = ($urandom % 2) == 1;
            else                 rv = ($urandom % 60) == 0;
            step(v, $urandom, 5'($urandom % 8), ($urandom % 4) != 0, mtr, $urandom, rv);
            if ((i % 150) == 149) begin
                @(negedge clk);
                check_outputs();
                quiet_inputs();
                reset = 1;
                #1;
                chk("rand_rst_reg_write", {31'd0, reg_write}, 32'd0);
                release_reset();
            end
        end
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
